// File: rtl/nibble_pair_assembler.sv
// Pairs consecutive 4-bit nibbles into (high, low) tuples, queues them in a small FIFO,
// and drains one pair per enabled cycle onto registered output fields.
module nibble_pair_assembler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       _i_clk,
  input  logic                       _i_rst,
  input  logic [3:0]                 _i_in_nibble,
  input  logic                       _i_in_valid,
  output logic                       _o_in_ready,
  input  logic                       _i_flush,
  input  logic                       _i_out_en,
  output logic [3:0]                 _o_output1,
  output logic [3:0]                 _o_output2,
  output logic                       _o_out_valid,
  output logic [CNT_W-1:0]           _o_pair_count,
  output logic [$clog2(DEPTH):0]     _o_level,
  output logic [0:0]                 _o_dbg_state
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  localparam logic [0:0] ST_HI = 1'b0;
  localparam logic [0:0] ST_LO = 1'b1;

  // Input handshake: a nibble is transferred on any edge where _i_in_valid and
  // _o_in_ready are both high; ready never depends on _i_in_valid or a same-edge pop.
  logic [0:0]       state_q, state_d;
  logic [3:0]       held_q, held_d;
  logic [7:0]       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic [3:0]       out1_q, out2_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic in_ready;
  logic accept;
  logic push;
  logic pop;

  assign in_ready = !_i_rst && ((state_q == ST_HI) || (level_q < LW'(DEPTH)));
  assign accept   = _i_in_valid && in_ready;
  // A flushed beat in LO is consumed but never reaches the FIFO.
  assign push     = accept && (state_q == ST_LO) && !_i_flush;
  assign pop      = _i_out_en && (level_q != '0);

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    if ((state_q == ST_LO) && _i_flush) begin
      state_d = ST_HI;
    end else if (accept) begin
      if (state_q == ST_HI) begin
        held_d  = _i_in_nibble;
        state_d = ST_LO;
      end else begin
        state_d = ST_HI;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      state_q     <= ST_HI;
      held_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      // Idle cycles drive zeros because the downstream pipeline samples every cycle.
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PW'(1);
        out1_q      <= mem_q[rd_ptr_q][7:4];
        out2_q      <= mem_q[rd_ptr_q][3:0];
        out_valid_q <= 1'b1;
        cnt_q       <= cnt_q + CNT_W'(1);
      end else begin
        out1_q      <= '0;
        out2_q      <= '0;
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge _i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {held_q, _i_in_nibble};
  end

  assign _o_in_ready   = in_ready;
  assign _o_output1    = out1_q;
  assign _o_output2    = out2_q;
  assign _o_out_valid  = out_valid_q;
  assign _o_pair_count = cnt_q;
  assign _o_level      = level_q;
  assign _o_dbg_state  = state_q;

endmodule

// File: tb/tb_nibble_pair_assembler.sv
// Bench for nibble_pair_assembler: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_nibble_pair_assembler;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [3:0]       in_nibble;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             out_en;
  logic [3:0]       output1;
  logic [3:0]       output2;
  logic             out_valid;
  logic [CNT_W-1:0] pair_count;
  logic [LW-1:0]    level;
  logic [0:0]       dbg_state;

  nibble_pair_assembler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    ._i_clk        (clk),
    ._i_rst        (rst),
    ._i_in_nibble  (in_nibble),
    ._i_in_valid   (in_valid),
    ._o_in_ready   (in_ready),
    ._i_flush      (flush),
    ._i_out_en     (out_en),
    ._o_output1    (output1),
    ._o_output2    (output2),
    ._o_out_valid  (out_valid),
    ._o_pair_count (pair_count),
    ._o_level      (level),
    ._o_dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued pairs, held high nibble, registered outputs
  logic [7:0]       exp_q[$];
  bit               held_m;
  logic [3:0]       hv_m;
  logic [3:0]       e1_m, e2_m;
  logic             ev_m;
  logic [CNT_W-1:0] ecnt_m;
  int               emitted_m;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic r);
    return !r && (!held_m || (exp_q.size() < DEPTH));
  endfunction

  task automatic model_edge(input logic v, input logic [3:0] n, input logic f,
                            input logic en, input logic r);
    logic       acc;
    logic [7:0] head;
    if (r) begin
      exp_q.delete();
      held_m = 0; hv_m = '0;
      e1_m = '0; e2_m = '0; ev_m = 1'b0; ecnt_m = '0;
      return;
    end
    acc = v && model_ready(1'b0);
    if (en && exp_q.size() > 0) begin
      head = exp_q.pop_front();
      e1_m = head[7:4]; e2_m = head[3:0]; ev_m = 1'b1;
      ecnt_m = ecnt_m + 1'b1;
      emitted_m++;
    end else begin
      e1_m = '0; e2_m = '0; ev_m = 1'b0;
    end
    if (held_m && f) begin
      held_m = 0;
    end else if (acc) begin
      if (!held_m) begin
        held_m = 1; hv_m = n;
      end else begin
        exp_q.push_back({hv_m, n});
        held_m = 0;
      end
    end
  endtask

  // Driver: apply inputs, check ready before the edge, check registered outputs after it.
  task automatic cycle(input logic v, input logic [3:0] n, input logic f,
                       input logic en, input logic r);
    rst = r; in_valid = v; in_nibble = n; flush = f; out_en = en;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, model_ready(r)});
    @(posedge clk);
    model_edge(v, n, f, en, r);
    #1;
    check("output1",    {28'd0, output1},  {28'd0, e1_m});
    check("output2",    {28'd0, output2},  {28'd0, e2_m});
    check("out_valid",  {31'd0, out_valid}, {31'd0, ev_m});
    check("pair_count", 32'(pair_count), 32'(ecnt_m));
    check("level",      32'(level), 32'(exp_q.size()));
    check("dbg_state",  {31'd0, dbg_state}, {31'd0, held_m});
  endtask

  task automatic send(input logic [3:0] n, input logic en);
    cycle(1'b1, n, 1'b0, en, 1'b0);
  endtask

  task automatic idle(input logic en, input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 4'h0, 1'b0, en, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_nibble = '0; flush = 1'b0; out_en = 1'b0;
    held_m = 0; hv_m = '0; e1_m = '0; e2_m = '0; ev_m = 1'b0; ecnt_m = '0; emitted_m = 0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    // First pair 0,1 with drain enabled
    send(4'h0, 1'b1);
    send(4'h1, 1'b1);
    idle(1'b1, 1);
    check("first_pair_valid", {31'd0, out_valid}, 32'd1);
    check("first_pair_low", {28'd0, output2}, 32'd1);
    idle(1'b1, 2);

    // Fill to DEPTH with drain off, then hold a high nibble
    for (int k = 1; k <= 8; k++) send(4'(k), 1'b0);
    send(4'h9, 1'b0);
    check("full_level", 32'(level), 32'd4);
    #1;
    check("full_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 8);

    // Low nibble accepted at level 3 while draining
    do_reset();
    for (int k = 0; k < 6; k++) send(4'(k + 3), 1'b0);
    send(4'hE, 1'b0);
    send(4'h4, 1'b1);
    check("level_hold_3", 32'(level), 32'd3);
    idle(1'b1, 6);

    // Flush discards held high nibble and the simultaneous beat
    send(4'hA, 1'b0);
    cycle(1'b1, 4'hB, 1'b1, 1'b0, 1'b0);
    send(4'hC, 1'b0);
    send(4'hD, 1'b0);
    idle(1'b1, 1);
    check("flush_pair", {24'd0, output1, output2}, 32'h000000CD);
    idle(1'b1, 3);

    // Reset mid-drain with entries queued and a held high nibble
    for (int k = 0; k < 6; k++) send(4'(k), 1'b0);
    send(4'hF, 1'b1);
    do_reset();
    check("rst_level", 32'(level), 32'd0);
    send(4'h2, 1'b1);
    send(4'h3, 1'b1);
    idle(1'b1, 1);
    check("post_rst_pair", {24'd0, output1, output2}, 32'h00000023);
    idle(1'b1, 1);

    // Counter wrap: 17 pairs after reset
    do_reset();
    for (int k = 0; k < 34; k++) send(4'(k), 1'b1);
    idle(1'b1, 6);
    check("count_wrap", 32'(pair_count), 32'd1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end
    idle(1'b1, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_pair_assembler.md
Name: nibble_pair_assembler

Overview:
- Upstream feeder for the tuple-input delay pipeline: accepts a stream of 4-bit nibbles under valid/ready, pairs consecutive nibbles into (high, low) tuples, and buffers completed pairs in a small FIFO.
- Drains one pair per enabled cycle onto registered output1/output2 fields that wire directly to the pipeline's two nibble inputs.
- The pipeline cannot stall, so pacing is controlled by an explicit drain enable.

Parameters:
- DEPTH, 4, pair-FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the emitted-pair counter.

Ports:
- _i_clk  in  1  clock; all state updates on rising edge.
- _i_rst  in  1  synchronous, active-high reset.
- _i_in_nibble  in  4  incoming nibble.
- _i_in_valid  in  1  nibble present.
- _o_in_ready  out  1  assembler can accept the nibble this cycle.
- _i_flush  in  1  discard a half-assembled pair.
- _i_out_en  in  1  permission to emit one pair this cycle.
- _o_output1  out  4  high nibble of emitted pair.
- _o_output2  out  4  low nibble of emitted pair.
- _o_out_valid  out  1  output fields carry a pair this cycle.
- _o_pair_count  out  CNT_W  pairs emitted since reset; wraps.
- _o_level  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset, applied at any clock edge including mid-pair or mid-drain:
  - state goes to HI; FIFO is emptied (pointers 0, level 0).
  - _o_output1, _o_output2 and _o_out_valid go to 0; _o_pair_count goes to 0.
  - _o_in_ready is forced to 0 combinationally while _i_rst is high.
- Assembly FSM, two states:
  - HI (no nibble held): _o_in_ready = 1. On _i_in_valid & ready, latch the nibble as held_hi and go to LO.
  - LO (held_hi valid): _o_in_ready = (level < DEPTH), using the registered level. On valid & ready, push {held_hi, nibble} into the FIFO and go to HI.
- Flush: _i_flush in LO forces HI and discards held_hi. Flush beats a simultaneous input beat, which is dropped but still counts as accepted if ready was high. Flush in HI has no effect. Flush never touches the FIFO.
- Drain, evaluated every edge:
  - If _i_out_en and level > 0 (registered): output1/output2 are loaded with the head pair, _o_out_valid goes to 1, the entry is popped, and _o_pair_count increments modulo 2^CNT_W.
  - Otherwise output1/output2 go to 0 and _o_out_valid goes to 0. The zero fields are required: the downstream pipeline consumes every cycle.
- Latency:
  - A pair whose low nibble is accepted at edge t enters the FIFO at t.
  - The earliest emission is registered at edge t+1, i.e. visible during the cycle after t+1.
  - The FIFO gives no same-cycle bypass.
- Push and pop at the same edge: both take effect and level is unchanged.
  - Ready at level = DEPTH stays 0 even if a pop occurs that edge; there is no ready-from-pop combinational path.
- FIFO pointers: wrap modulo DEPTH. Level is an explicit counter with range 0..DEPTH; it never overflows or underflows.
- Order: strict FIFO. output1 is always the earlier nibble of its pair.

Test Plan:
- Reset, then nibbles 0x0, 0x1 with _i_out_en = 1. Required: one cycle with output1 = 0, output2 = 1, out_valid = 1, pair_count = 1; all other cycles zeros. A chained delay_3 then shows result 0x01 three cycles later, then 0x00.
- DEPTH = 4, _i_out_en = 0: push pairs (1,2), (3,4), (5,6), (7,8), then hi 0x9.
  - Required: level = 4 and in_ready = 0 in LO.
  - Raise out_en: outputs 0x12, 0x34, 0x56, 0x78 on consecutive cycles; in_ready returns to 1 the cycle after level reaches 3; the (9, low) pair is emitted fifth.
- At level = 3 with out_en = 1, accept a low nibble completing a pair. Required: level stays 3 at that edge and the pair emits in order with no loss or duplication.
- Send hi 0xA, assert _i_flush with valid nibble 0xB, then send 0xC, 0xD. Required: only pair (C, D) emitted; pair_count advances by 1.
- Mid-drain with 3 entries queued and held_hi = 0xF: assert _i_rst for one cycle. Required: next cycle level = 0, out_valid = 0, outputs 0, pair_count = 0. A subsequent 0x2, 0x3 yields (2, 3), confirming held_hi was cleared.
- With CNT_W = 4: emit 17 pairs. Required: pair_count wraps to 1.
